// File: rtl/fixed_accumulator.sv
// rtl/fixed_accumulator.sv - 8.8 fixed-point burst accumulator with sticky overflow (optional FIXED_ACC_SATURATE_EN)
module fixed_accumulator #(
    parameter int MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_ovf,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf,
    output logic [7:0]  out_count
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_TERMS);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t      state;
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
    logic        in_ready_r;
    logic        out_valid_r;

    logic        in_fire;
    logic        out_fire;
    logic [16:0] sum17;
    logic [7:0]  cnt_inc;
    logic [15:0] acc_first;
    logic [15:0] acc_next;

    assign in_fire  = in_valid & in_ready_r;
    assign out_fire = out_valid_r & out_ready;

    // Datapath: 17-bit add exposes the carry; saturating build clamps on any overflow source
    always_comb begin
        sum17   = {1'b0, acc} + {1'b0, in_data};
        cnt_inc = cnt + 8'd1;
`ifdef FIXED_ACC_SATURATE_EN
        acc_first = in_ovf ? 16'hFFFF : in_data;
        acc_next  = (ovf | sum17[16] | in_ovf) ? 16'hFFFF : sum17[15:0];
`else
        acc_first = in_data;
        acc_next  = sum17[15:0];
`endif
    end

    // Burst FSM; handshake flags are registered so they depend on state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= 16'd0;
            cnt         <= 8'd0;
            ovf         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        acc <= acc_first;
                        cnt <= 8'd1;
                        ovf <= in_ovf;
                        if (in_last || (MAX_CNT == 8'd1)) begin
                            state       <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        acc <= acc_next;
                        cnt <= cnt_inc;
                        ovf <= ovf | sum17[16] | in_ovf;
                        if (in_last || (cnt_inc == MAX_CNT)) begin
                            state       <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state       <= IDLE;
                        acc         <= 16'd0;
                        cnt         <= 8'd0;
                        ovf         <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    acc         <= 16'd0;
                    cnt         <= 8'd0;
                    ovf         <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_fixed_accumulator.sv
// tb/tb_fixed_accumulator.sv - scoreboard testbench for fixed_accumulator
module tb_fixed_accumulator;

    localparam int MAX_TERMS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_ovf = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    fixed_accumulator #(.MAX_TERMS(MAX_TERMS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
        logic [7:0]  count;
    } res_t;

    res_t sb[$];
    int   m_acc;
    int   m_cnt;
    bit   m_ovf;
    int   passed = 0;
    int   total = 0;

`ifdef FIXED_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Present one term, wait for acceptance, update the reference model
    task automatic send_term(input logic [15:0] d, input logic o, input logic l);
        int   n;
        int   t;
        res_t r;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            return;
        end
        t = m_acc + int'(d);
        m_ovf = m_ovf | o | (t > 65535);
        if (SAT && m_ovf) m_acc = 65535;
        else m_acc = t % 65536;
        m_cnt++;
        @(negedge clk);
        if (l || m_cnt == MAX_TERMS) begin
            r.sum   = 16'(m_acc);
            r.ovf   = m_ovf;
            r.count = 8'(m_cnt);
            sb.push_back(r);
            model_reset();
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ovf   = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0})
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h ovf=%b cnt=%0d required 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit   ok;
        res_t e;
        send_term(16'h0180, 1'b0, 1'b0);
        send_term(16'h0040, 1'b0, 1'b0);
        send_term(16'h0240, 1'b0, 1'b1);
        idle_in();
        total++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
        else passed++;
        wait_out(ok);
        total++;
        if ({out_sum, out_ovf, out_count} !== {16'h0400, 1'b0, 8'd3})
            $display("FAIL basic_const: got %h/%b/%0d required 0400/0/3", out_sum, out_ovf, out_count);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL basic_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL basic_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
        total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_release: rdy/vld=%b%b required 10", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        bit   ok;
        res_t e;
        send_term(16'hFF00, 1'b0, 1'b0);
        send_term(16'h0200, 1'b0, 1'b1);
        idle_in();
        wait_out(ok);
        total++;
        if ({out_sum, out_ovf, out_count} !== {(SAT ? 16'hFFFF : 16'h0100), 1'b1, 8'd2})
            $display("FAIL ovf_const: got %h/%b/%0d required %h/1/2", out_sum, out_ovf, out_count, SAT ? 16'hFFFF : 16'h0100);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL ovf_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL ovf_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
    endtask

    task automatic test_max_terms();
        bit   ok;
        res_t e;
        for (int i = 0; i < MAX_TERMS; i++) send_term(16'h0001, 1'b0, 1'b0);
        idle_in();
        wait_out(ok);
        total++;
        if ({in_ready, out_sum, out_ovf, out_count} !== {1'b0, 16'h0010, 1'b0, 8'd16})
            $display("FAIL max_const: got rdy=%b %h/%b/%0d required 0 0010/0/16", in_ready, out_sum, out_ovf, out_count);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL max_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL max_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit   ok;
        res_t e;
        send_term(16'h0003, 1'b0, 1'b0);
        send_term(16'h0004, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        in_ovf   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 16'h0007, 1'b0, 8'd2})
                $display("FAIL stall_stable[%0d]: got vld=%b rdy=%b %h/%b/%0d required 1 0 0007/0/2",
                         i, out_valid, in_ready, out_sum, out_ovf, out_count);
            else passed++;
            @(negedge clk);
        end
        wait_out(ok);
        total++;
        if (!ok || sb.size() == 0) $display("FAIL stall_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL stall_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
        total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL stall_idle: rdy/vld=%b%b required 10", in_ready, out_valid);
        else passed++;
        send_term(16'h0100, 1'b0, 1'b1);
        idle_in();
        wait_out(ok);
        total++;
        if ({out_sum, out_ovf, out_count} !== {16'h0100, 1'b0, 8'd1})
            $display("FAIL fresh_const: got %h/%b/%0d required 0100/0/1", out_sum, out_ovf, out_count);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL fresh_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL fresh_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
    endtask

    task automatic test_single_ovf();
        bit   ok;
        res_t e;
        send_term(16'h0005, 1'b1, 1'b1);
        idle_in();
        wait_out(ok);
        total++;
        if ({out_sum, out_ovf, out_count} !== {(SAT ? 16'hFFFF : 16'h0005), 1'b1, 8'd1})
            $display("FAIL single_const: got %h/%b/%0d required %h/1/1", out_sum, out_ovf, out_count, SAT ? 16'hFFFF : 16'h0005);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL single_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL single_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
    endtask

    task automatic test_async_reset();
        bit   ok;
        res_t e;
        send_term(16'h0100, 1'b1, 1'b0);
        send_term(16'h0200, 1'b0, 1'b0);
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0})
            $display("FAIL rst_mid: got rdy=%b vld=%b %h/%b/%0d required 1 0 0000/0/0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        else passed++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_term(16'h0020, 1'b0, 1'b1);
        idle_in();
        sb.delete();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_count} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0})
            $display("FAIL rst_hold: got rdy=%b vld=%b %h/%b/%0d required 1 0 0000/0/0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_term(16'h0030, 1'b0, 1'b1);
        idle_in();
        wait_out(ok);
        total++;
        if ({out_sum, out_ovf, out_count} !== {16'h0030, 1'b0, 8'd1})
            $display("FAIL post_rst_const: got %h/%b/%0d required 0030/0/1", out_sum, out_ovf, out_count);
        else passed++;
        total++;
        if (!ok || sb.size() == 0) $display("FAIL post_rst_sb: out_valid=%b queued=%0d required 1 and >0", ok, sb.size());
        else begin
            e = sb.pop_front();
            if ({out_sum, out_ovf, out_count} !== e)
                $display("FAIL post_rst_sb: got %h/%b/%0d required %h/%b/%0d", out_sum, out_ovf, out_count, e.sum, e.ovf, e.count);
            else passed++;
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_max_terms();
        test_back_to_back();
        test_single_ovf();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fixed_accumulator.md
# fixed_accumulator

Sequential accumulator for 16-bit unsigned 8.8 fixed-point terms (IIIIIIII.FFFFFFFF). It sits directly downstream of `fixed_multi`: it takes that block's `result`/`overflow` pair one term per handshake and sums a burst of products into a dot-product result. It presents the sum with a sticky overflow flag on a valid/ready output port.

## Interface
- `MAX_TERMS`, default 16: maximum terms per burst; the burst closes automatically when reached; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a term is presented.
- `in_ready` output 1: the block accepts a term this cycle.
- `in_data` input 16: 8.8 unsigned term (`fixed_multi.result`).
- `in_ovf` input 1: the upstream term already overflowed (`fixed_multi.overflow`).
- `in_last` input 1: the presented term closes the burst.
- `out_valid` output 1: the burst result is available.
- `out_ready` input 1: the consumer takes the result.
- `out_sum` output 16: 8.8 accumulated sum.
- `out_ovf` output 1: sticky overflow for the burst.
- `out_count` output 8: number of terms accepted in the burst.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready` is high at a clock edge.
  - An output transfer occurs when `out_valid & out_ready` is high at a clock edge.
- FSM states are IDLE, ACC and HOLD.
  - IDLE: `acc`=0, `cnt`=0, `ovf`=0, `in_ready`=1. An input transfer loads `acc`=`in_data`, `cnt`=1, `ovf`=`in_ovf`. It then goes to HOLD if `in_last` or `MAX_TERMS`==1, otherwise to ACC.
  - ACC: `in_ready`=1. An input transfer computes the 17-bit sum `{c,s}`=`acc`+`in_data`, then sets `acc`=`s`, `cnt`+=1 and `ovf` |= `c` | `in_ovf`. It goes to HOLD if `in_last` or the new `cnt`==`MAX_TERMS`.
  - HOLD: `in_ready`=0, `out_valid`=1. `out_sum`, `out_ovf` and `out_count` are stable until the output transfer. After the transfer the block clears `acc`, `cnt` and `ovf` and goes to IDLE.
- Arithmetic: unsigned modulo-2^16 wrap. The binary point is fixed, so no alignment is needed.
- Once `ovf` is set it stays set until the burst is consumed.
- `in_data` and `in_ovf` are ignored when no input transfer occurs.
- `in_ready` is a function of state only. `out_valid` is a function of state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Timing
- Reset (asynchronous assert, synchronous release) gives: state=IDLE, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_count`=0.
- Throughput: one term per cycle while in IDLE/ACC.
- Latency: `out_valid` rises in the cycle after the edge that accepted the closing term.
- The cycle after an output transfer, the block is in IDLE with `in_ready`=1. Two bursts are therefore separated by a minimum of one bubble cycle at the input.
- A reset asserted mid-burst or in HOLD discards the partial or pending result immediately. No output transfer is reported for it.
- If `in_last` arrives on the same term where `cnt` reaches `MAX_TERMS`, the block closes the burst once.
- `in_last` on a non-transfer cycle has no effect.

## Configuration
- `FIXED_ACC_SATURATE_EN`:
  - When defined, an ACC-state carry (`c`=1) or an accepted `in_ovf`=1 clamps `acc` to 16'hFFFF. `acc` then remains 16'hFFFF for the rest of the burst, and `out_ovf` is set as usual.
  - When undefined, `acc` wraps modulo 2^16 and `in_data` is summed as given, regardless of `in_ovf`.

## Test plan
- Reset, then feed 3 terms 16'h0180 (1.5), 16'h0040 (0.25), 16'h0240 (2.25, `in_last`) back-to-back -> `out_valid` in the cycle after the 3rd accept with `out_sum`=16'h0400, `out_ovf`=0, `out_count`=3.
- Feed 16'hFF00 then 16'h0200 with `in_last` -> without the macro `out_sum`=16'h0100 and `out_ovf`=1; with `FIXED_ACC_SATURATE_EN`, `out_sum`=16'hFFFF and `out_ovf`=1.
- Feed `MAX_TERMS`=16 terms of 16'h0001 with `in_last` never set -> auto-close with `out_sum`=16'h0010 and `out_count`=16; `in_ready`=0 while in HOLD.
- Hold `out_ready`=0 for 5 cycles in HOLD while driving `in_valid`=1 -> outputs are stable and no term is accepted. Raise `out_ready` -> IDLE in the next cycle, after which the next term (16'h0100) is accepted and starts a fresh sum.
- Single term 16'h0005 with `in_ovf`=1 and `in_last` -> `out_sum`=16'h0005 (16'hFFFF with the macro), `out_ovf`=1, `out_count`=1.
- Assert `rst_n`=0 asynchronously mid-burst and separately in HOLD -> outputs return to the reset values immediately. The next burst sums from 0.
